// File: rtl/secded_pkg.sv
// Shared SECDED types and position-mapping helpers for the decoder and the future encoder/scrubber.
package secded_pkg;

  typedef enum logic [1:0] {
    ST_OK  = 2'b00,
    ST_SGL = 2'b01,
    ST_DBL = 2'b10
  } status_t;

  // Widest codeword the helpers handle (K=57 -> R=6 -> N=64).
  localparam int MAX_N = 64;

  function automatic int calc_r(input int k);
    int r;
    r = 7;
    for (int i = 7; i >= 1; i--)
      if ((1 << i) >= k + i + 1) r = i;
    return r;
  endfunction

  function automatic logic is_pow2(input int pos);
    return (pos != 0) && ((pos & (pos - 1)) == 0);
  endfunction

  // Gathers the non-parity positions 1..n-1 into a dense LSB-first data word.
  function automatic logic [MAX_N-1:0] extract_data(input logic [MAX_N-1:0] code, input int n);
    logic [MAX_N-1:0] d;
    logic [5:0]       j;
    d = '0;
    j = '0;
    for (int pos = 1; pos < MAX_N; pos++) begin
      if (pos < n && !is_pow2(pos)) begin
        d[j] = code[pos];
        j    = j + 6'd1;
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/secded_stream_decoder_if.sv
// Codeword-in / data-out streaming handshake bundle for the SECDED decoder.
interface secded_stream_decoder_if
  import secded_pkg::*;
#(
  parameter int K = 11
);
  localparam int R = calc_r(K);
  localparam int N = K + R + 1;

  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_code;
  logic         out_valid;
  logic         out_ready;
  logic [K-1:0] out_data;
  status_t      out_status;

  modport master (
    output in_valid, in_code, out_ready,
    input  in_ready, out_valid, out_data, out_status
  );

  modport slave (
    input  in_valid, in_code, out_ready,
    output in_ready, out_valid, out_data, out_status
  );
endinterface

// File: rtl/secded_syndrome.sv
// Hamming syndrome (XOR of set-bit indices 1..N-1) and overall parity of a codeword.
module secded_syndrome #(
  parameter int N = 16,
  parameter int R = 4
) (
  input  logic [N-1:0] code,
  output logic [R-1:0] s,
  output logic         q
);
  always_comb begin
    s = '0;
    for (int i = 1; i < N; i++)
      if (code[i]) s = s ^ i[R-1:0];
    q = ^code;
  end
endmodule

// File: rtl/secded_stream_decoder.sv
// Two-stage streaming SECDED decoder with valid/ready on both sides and saturating stats.
module secded_stream_decoder
  import secded_pkg::*;
#(
  parameter int K     = 11,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  secded_stream_decoder_if.slave io,
  input  logic                  cnt_clear,
  output logic [CNT_W-1:0]      cnt_words,
  output logic [CNT_W-1:0]      cnt_sgl,
  output logic [CNT_W-1:0]      cnt_dbl
);
  localparam int R      = calc_r(K);
  localparam int N      = K + R + 1;
  localparam int STAGES = 2;

  typedef struct packed {
    logic [N-1:0] code;
    logic [R-1:0] syn;
    logic         q;
  } s1_t;

  typedef struct packed {
    logic [K-1:0] data;
    status_t      st;
  } s2_t;

  logic [STAGES:1]  vld_pipe;
  s1_t              s1_q;
  s2_t              s2_q;
  logic             s1_ready, s2_ready, out_hs;
  logic [R-1:0]     syn;
  logic             par;
  logic [N-1:0]     fixed;
  logic [MAX_N-1:0] ext;
  logic [K-1:0]     dec_data;
  status_t          dec_st;
  logic             unused_ext_hi;

  secded_syndrome #(.N(N), .R(R)) u_syn (
    .code (io.in_code),
    .s    (syn),
    .q    (par)
  );

  // A stage loads when empty or when its contents move on this cycle.
  assign s2_ready    = !vld_pipe[2] || io.out_ready;
  assign s1_ready    = !vld_pipe[1] || s2_ready;
  assign out_hs      = vld_pipe[2] && io.out_ready;
  assign io.in_ready = s1_ready;

  always_comb begin
    fixed  = s1_q.code;
    dec_st = ST_OK;
    if (s1_q.syn == '0) begin
      dec_st = s1_q.q ? ST_SGL : ST_OK;
    end else if (!s1_q.q || int'(s1_q.syn) > N - 1) begin
      dec_st = ST_DBL;
    end else begin
      fixed[s1_q.syn] = ~fixed[s1_q.syn];
      dec_st          = ST_SGL;
    end
    ext      = extract_data(MAX_N'(fixed), N);
    dec_data = ext[K-1:0];
  end

  assign unused_ext_hi = ^ext[MAX_N-1:K];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_pipe <= '0;
      s1_q     <= '0;
      s2_q     <= '{data: '0, st: ST_OK};
    end else begin
      if (s1_ready) begin
        vld_pipe[1] <= io.in_valid;
        // Payload only moves with a valid word so X on an idle bus never reaches the outputs.
        if (io.in_valid) s1_q <= '{code: io.in_code, syn: syn, q: par};
      end
      if (s2_ready) begin
        vld_pipe[2] <= vld_pipe[1];
        if (vld_pipe[1]) s2_q <= '{data: dec_data, st: dec_st};
      end
    end
  end

  assign io.out_valid  = vld_pipe[2];
  assign io.out_data   = s2_q.data;
  assign io.out_status = s2_q.st;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Clear wins over a same-cycle handshake: that word is deliberately not counted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_words <= '0;
      cnt_sgl   <= '0;
      cnt_dbl   <= '0;
    end else if (cnt_clear) begin
      cnt_words <= '0;
      cnt_sgl   <= '0;
      cnt_dbl   <= '0;
    end else if (out_hs) begin
      cnt_words <= sat_inc(cnt_words);
      if (s2_q.st == ST_SGL) cnt_sgl <= sat_inc(cnt_sgl);
      if (s2_q.st == ST_DBL) cnt_dbl <= sat_inc(cnt_dbl);
    end
  end

endmodule

// File: tb/tb_secded_stream_decoder.sv
// Directed bench: K=11 decoder with 4-bit counters, plus a K=26 decoder checked against a local encoder.
module tb_secded_stream_decoder;
  import secded_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  secded_stream_decoder_if #(.K(11)) a_if ();
  secded_stream_decoder_if #(.K(26)) b_if ();

  logic        a_clr = 1'b0, b_clr = 1'b0;
  logic [3:0]  a_words, a_sgl, a_dbl;
  logic [15:0] b_words, b_sgl, b_dbl;

  secded_stream_decoder #(.K(11), .CNT_W(4)) u_a (
    .clk(clk), .reset_n(reset_n), .io(a_if.slave), .cnt_clear(a_clr),
    .cnt_words(a_words), .cnt_sgl(a_sgl), .cnt_dbl(a_dbl)
  );

  secded_stream_decoder #(.K(26), .CNT_W(16)) u_b (
    .clk(clk), .reset_n(reset_n), .io(b_if.slave), .cnt_clear(b_clr),
    .cnt_words(b_words), .cnt_sgl(b_sgl), .cnt_dbl(b_dbl)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with an empty pipeline; returns at the negedge after the output handshake.
  task automatic a_send_recv(input logic [15:0] c, input logic [10:0] ed, input logic [1:0] es,
                             input string tag);
    a_if.out_ready = 1'b1;
    a_if.in_valid  = 1'b1;
    a_if.in_code   = c;
    #1 chk({tag, "_in_rdy"}, 64'(a_if.in_ready), 64'd1);
    @(negedge clk);
    a_if.in_valid = 1'b0;
    a_if.in_code  = 16'hxxxx;
    #1 chk({tag, "_lat1"}, 64'(a_if.out_valid), 64'd0);
    @(negedge clk);
    chk({tag, "_vld"}, 64'(a_if.out_valid), 64'd1);
    chk({tag, "_data"}, 64'(a_if.out_data), 64'(ed));
    chk({tag, "_st"}, 64'(a_if.out_status), 64'(es));
    @(negedge clk);
  endtask

  task automatic b_send_recv(input logic [31:0] c, input logic [25:0] ed, input logic [1:0] es,
                             input string tag);
    b_if.out_ready = 1'b1;
    b_if.in_valid  = 1'b1;
    b_if.in_code   = c;
    @(negedge clk);
    b_if.in_valid = 1'b0;
    b_if.in_code  = 32'hxxxxxxxx;
    @(negedge clk);
    chk({tag, "_vld"}, 64'(b_if.out_valid), 64'd1);
    chk({tag, "_data"}, 64'(b_if.out_data), 64'(ed));
    chk({tag, "_st"}, 64'(b_if.out_status), 64'(es));
    @(negedge clk);
  endtask

  function automatic logic [31:0] enc26(input logic [25:0] d);
    logic [31:0] c;
    logic        x;
    int          j;
    c = '0;
    j = 0;
    for (int p = 1; p < 32; p++)
      if ((p & (p - 1)) != 0) begin
        c[p] = d[j];
        j++;
      end
    for (int b = 0; b < 5; b++) begin
      x = 1'b0;
      for (int p = 1; p < 32; p++)
        if (((p >> b) & 1) == 1) x = x ^ c[p];
      c[1 << b] = x;
    end
    c[0] = ^c;
    return c;
  endfunction

  function automatic logic [25:0] ext26(input logic [31:0] c);
    logic [25:0] d;
    int          j;
    d = '0;
    j = 0;
    for (int p = 1; p < 32; p++)
      if ((p & (p - 1)) != 0) begin
        d[j] = c[p];
        j++;
      end
    return d;
  endfunction

  logic [15:0] st_code [8] = '{16'h0000, 16'hFFFF, 16'h0020, 16'h7FFF,
                               16'h0001, 16'h0028, 16'hFFFC, 16'h0000};
  logic [10:0] st_data [8] = '{11'h000, 11'h7FF, 11'h000, 11'h7FF,
                               11'h000, 11'h003, 11'h7FF, 11'h000};
  logic [1:0]  st_stat [8] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b00};

  initial begin
    int          wi, ri, occ, kind, i1, i2, nsgl, ndbl;
    logic        held_v, hs_in, hs_out;
    logic [10:0] held_d;
    logic [1:0]  held_s;
    logic [25:0] d26;
    logic [31:0] c26;

    a_if.in_valid = 1'b0; a_if.in_code = '0; a_if.out_ready = 1'b0;
    b_if.in_valid = 1'b0; b_if.in_code = '0; b_if.out_ready = 1'b0;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 64'(a_if.out_valid), 64'd0);
    chk("rst_out_data", 64'(a_if.out_data), 64'd0);
    chk("rst_out_status", 64'(a_if.out_status), 64'd0);
    chk("rst_cnt_words", 64'(a_words), 64'd0);
    reset_n = 1'b1;
    #1 chk("rst_in_ready", 64'(a_if.in_ready), 64'd1);

    // Two clean words back to back, 2-cycle latency
    @(negedge clk);
    a_if.out_ready = 1'b1;
    a_if.in_valid = 1'b1; a_if.in_code = 16'h0000;
    @(negedge clk);
    a_if.in_code = 16'hFFFF;
    #1 chk("b2b_lat1", 64'(a_if.out_valid), 64'd0);
    @(negedge clk);
    a_if.in_valid = 1'b0; a_if.in_code = 16'hxxxx;
    chk("b2b_w0_vld", 64'(a_if.out_valid), 64'd1);
    chk("b2b_w0_data", 64'(a_if.out_data), 64'h000);
    chk("b2b_w0_st", 64'(a_if.out_status), 64'd0);
    @(negedge clk);
    chk("b2b_w1_data", 64'(a_if.out_data), 64'h7FF);
    chk("b2b_w1_st", 64'(a_if.out_status), 64'd0);
    @(negedge clk);
    chk("b2b_drained", 64'(a_if.out_valid), 64'd0);
    chk("b2b_cnt_words", 64'(a_words), 64'd2);

    a_send_recv(16'h0020, 11'h000, 2'b01, "sgl_bit5");
    a_send_recv(16'h7FFF, 11'h7FF, 2'b01, "sgl_bit15");
    a_send_recv(16'h0001, 11'h000, 2'b01, "sgl_p0");
    chk("sgl_cnt", 64'(a_sgl), 64'd3);
    a_send_recv(16'h0028, 11'h003, 2'b10, "dbl_3_5");
    a_send_recv(16'hFFFC, 11'h7FF, 2'b10, "dbl_0_1");
    chk("dbl_cnt", 64'(a_dbl), 64'd2);
    chk("dbl_cnt_words", 64'(a_words), 64'd7);

    // Stall pattern: out_ready 1,0,0 repeating; occ models words held inside the decoder
    a_clr = 1'b1;
    @(negedge clk);
    a_clr = 1'b0;
    wi = 0; ri = 0; occ = 0; held_v = 1'b0; held_d = '0; held_s = '0;
    for (int cyc = 0; cyc < 60 && ri < 8; cyc++) begin
      a_if.out_ready = (cyc % 3 == 0);
      a_if.in_valid  = (wi < 8);
      a_if.in_code   = (wi < 8) ? st_code[wi] : 16'hxxxx;
      #1;
      chk("stall_in_ready", 64'(a_if.in_ready), 64'(!(occ == 2 && !a_if.out_ready)));
      if (held_v) begin
        chk("stall_hold_vld", 64'(a_if.out_valid), 64'd1);
        chk("stall_hold_data", 64'(a_if.out_data), 64'(held_d));
        chk("stall_hold_st", 64'(a_if.out_status), 64'(held_s));
      end
      hs_out = a_if.out_valid && a_if.out_ready;
      hs_in  = a_if.in_valid && a_if.in_ready;
      if (hs_out) begin
        chk("stall_order_data", 64'(a_if.out_data), 64'(st_data[ri]));
        chk("stall_order_st", 64'(a_if.out_status), 64'(st_stat[ri]));
        ri++;
      end
      held_v = a_if.out_valid && !a_if.out_ready;
      held_d = a_if.out_data;
      held_s = a_if.out_status;
      occ = occ + int'(hs_in) - int'(hs_out);
      if (hs_in) wi++;
      @(negedge clk);
    end
    a_if.in_valid = 1'b0;
    chk("stall_delivered", 64'(ri), 64'd8);
    chk("stall_cnt_words", 64'(a_words), 64'd8);
    chk("stall_cnt_sgl", 64'(a_sgl), 64'd3);

    // Saturation of 4-bit counters
    a_clr = 1'b1;
    @(negedge clk);
    a_clr = 1'b0;
    a_if.out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      a_if.in_valid = 1'b1;
      a_if.in_code  = 16'h0020;
      @(negedge clk);
    end
    a_if.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("sat_cnt_sgl", 64'(a_sgl), 64'd15);
    chk("sat_cnt_words", 64'(a_words), 64'd15);
    chk("sat_cnt_dbl", 64'(a_dbl), 64'd0);

    // Clear coinciding with an output handshake
    a_if.in_valid = 1'b1; a_if.in_code = 16'h0028;
    @(negedge clk);
    a_if.in_valid = 1'b0;
    @(negedge clk);
    chk("clr_hs_vld", 64'(a_if.out_valid), 64'd1);
    a_clr = 1'b1;
    @(negedge clk);
    a_clr = 1'b0;
    chk("clr_hs_words", 64'(a_words), 64'd0);
    chk("clr_hs_sgl", 64'(a_sgl), 64'd0);
    chk("clr_hs_dbl", 64'(a_dbl), 64'd0);
    chk("clr_hs_consumed", 64'(a_if.out_valid), 64'd0);
    @(negedge clk);
    chk("clr_hs_words_after", 64'(a_words), 64'd0);

    // Asynchronous reset with two words in flight
    a_if.out_ready = 1'b0;
    a_if.in_valid = 1'b1; a_if.in_code = 16'hFFFF;
    @(negedge clk);
    a_if.in_code = 16'h0020;
    @(negedge clk);
    a_if.in_valid = 1'b0;
    #1;
    chk("inflt_vld", 64'(a_if.out_valid), 64'd1);
    chk("inflt_full_ready", 64'(a_if.in_ready), 64'd0);
    #1 reset_n = 1'b0;
    #1;
    chk("arst_out_valid", 64'(a_if.out_valid), 64'd0);
    chk("arst_out_data", 64'(a_if.out_data), 64'd0);
    chk("arst_in_ready", 64'(a_if.in_ready), 64'd1);
    @(negedge clk);
    reset_n = 1'b1;
    a_if.out_ready = 1'b1;
    @(negedge clk);
    chk("arst_no_ghost", 64'(a_if.out_valid), 64'd0);
    chk("arst_cnt_words", 64'(a_words), 64'd0);
    a_send_recv(16'h0028, 11'h003, 2'b10, "post_rst");
    chk("post_rst_words", 64'(a_words), 64'd1);
    chk("post_rst_dbl", 64'(a_dbl), 64'd1);

    // K=26 random single/double flips against the local encoder
    nsgl = 0; ndbl = 0;
    for (int i = 0; i < 24; i++) begin
      kind = i % 3;
      d26  = 26'($urandom);
      i1   = int'($urandom_range(0, 31));
      i2   = (i1 + 1 + int'($urandom_range(0, 30))) % 32;
      c26  = enc26(d26);
      if (kind >= 1) c26[i1] = ~c26[i1];
      if (kind == 2) c26[i2] = ~c26[i2];
      if (kind == 1) nsgl++;
      if (kind == 2) ndbl++;
      b_send_recv(c26, (kind == 2) ? ext26(c26) : d26, 2'(kind), "k26");
    end
    chk("k26_cnt_words", 64'(b_words), 64'd24);
    chk("k26_cnt_sgl", 64'(b_sgl), 64'(nsgl));
    chk("k26_cnt_dbl", 64'(b_dbl), 64'(ndbl));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/secded_stream_decoder.md
Name: secded_stream_decoder

Overview:
Streaming Hamming SECDED decoder, the hardware successor to the program-2 decode algorithm. It is parametrised in data width and carries a valid/ready handshake on both sides. Each cycle it accepts one codeword, corrects single-bit errors and flags double-bit errors. It keeps saturating error-statistics counters and sits between a memory read port and a memory write port in the accelerator datapath.

Parameters:
K, 11, data bits per word; any value 4..57.
R, derived, Hamming parity bits: smallest R with 2^R >= K+R+1; K=11 gives R=4. Localparam, not overridable.
N, derived, codeword width K+R+1; K=11 gives 16. Localparam.
CNT_W, 16, width of each statistics counter.

Ports:
clk  in  1  rising-edge clock
reset_n  in  1  asynchronous active-low reset
in_valid  in  1  codeword present
in_ready  out  1  decoder can accept
in_code  in  N  codeword. Bit 0 = overall parity p0; bit 2^j = parity p(2^j); the remaining positions hold data bits d[1..K], in ascending order from the LSB.
out_valid  out  1  result present
out_ready  in  1  consumer accepts
out_data  out  K  corrected data, d[K:1] mapped to out_data[K-1:0]
out_status  out  2  2'b00 clean, 2'b01 single error corrected, 2'b10 double/uncorrectable
cnt_clear  in  1  synchronous clear of all counters
cnt_words  out  CNT_W  words delivered
cnt_sgl  out  CNT_W  status 01 words delivered
cnt_dbl  out  CNT_W  status 10 words delivered

Behaviour:
- Reset (reset_n low, asynchronous): pipeline valid bits cleared; out_valid=0, out_data=0, out_status=00, all counters 0; in_ready=1 once reset_n is high.
- Mid-operation reset discards in-flight words. No output is produced for them and no counter is updated.
- Two-stage pipeline:
  - S1 registers the syndrome s[R-1:0], the overall-parity mismatch q and the raw codeword.
  - S2 registers the corrected data and the status.
  - Latency 2 cycles from in accept to out_valid with out_ready held high; throughput 1 word/cycle.
- Stage advance: a stage loads when it is empty or its downstream stage advances this cycle. in_ready = !S1_valid || S1_advance. This is combinational from out_ready; there is no combinational in_valid->out_valid path.
- Syndrome s = XOR of the indices of all set bits in positions 1..N-1. q = XOR of all N bits.
- Classification:
  - s==0, q==0: status 00, data unchanged.
  - s==0, q==1: p0 flipped; status 01, data unchanged.
  - s!=0, q==1, s<=N-1: flip bit s, extract data, status 01.
  - s!=0, q==0: status 10.
  - s>N-1 (possible only when N is not a power of two): status 10.
  - For status 10, out_data = data extracted uncorrected.
- Output holds stable while out_valid && !out_ready. Inputs change only on accept.
- Counters update on an out handshake (out_valid && out_ready):
  - cnt_words +1, plus cnt_sgl or cnt_dbl per status.
  - Each counter saturates at all-ones and does not wrap.
  - cnt_clear has priority: on a same-cycle clear and handshake, the counters become 0 and that word is not counted.
- in_code with in_valid low is ignored. X on in_code while invalid must not propagate to outputs.

Decomposition:
- secded_pkg holds:
  - typedef enum logic[1:0] status_t {ST_OK=2'b00, ST_SGL=2'b01, ST_DBL=2'b10}
  - function calc_r(K)
  - function is_pow2(pos), used for data/parity position mapping
  - function extract_data(code), parametrised via the K/N localparams
- One natural combinational sub-module, secded_syndrome: inputs the codeword, outputs s and q. It is reused by a future encoder/scrubber.

Test Plan:
- K=11. Inputs in_code 16'h0000, 16'hFFFF (data 11'h7FF), out_ready=1 -> outputs 2 cycles later: out_data 11'h000 status 00, then 11'h7FF status 00; cnt_words=2.
- Single flips 16'h0020 (bit 5, data d2), 16'h7FFF (bit 15), 16'h0001 (p0) -> data 000/7FF/000, status 01 each; cnt_sgl=3.
- Double flips 16'h0028 (bits 3,5) and 16'hFFFC (bits 0,1) -> status 10; out_msb=1; cnt_dbl=2.
- Back-to-back 8 words with out_ready toggling 1,0,0,1,... -> no word lost or duplicated, order preserved, outputs stable while stalled, in_ready low when both stages are full.
- Counter saturation with CNT_W=4: 20 single-error words -> cnt_sgl=15 and cnt_words=15 (both stuck). cnt_clear asserted in the same cycle as a handshake -> all counters 0.
- Assert reset_n low for 1 cycle with 2 words in flight -> out_valid=0 immediately (async), no counter increment, next word decodes normally; repeat with K=26 (N=32) random single/double flips against the reference model.
